// File: rtl/insn_decode_function_pkg.sv
// Shared constants for the 16-bit instruction decoder: field positions,
// execute-stage operation codes and the registered decode record.
package insn_decode_function_pkg;

  localparam int INSTR_W   = 16;
  localparam int EXE_W     = 4;
  localparam int REG_IDX_W = 2;
  localparam int IMM_W     = 8;

  // Field positions within the instruction word.
  localparam int I_BIT   = 15;
  localparam int OP_LSB  = 12;
  localparam int OP_W    = 3;
  localparam int DST_LSB = 10;
  localparam int IN1_LSB = 8;
  localparam int IN2_LSB = 6;
  localparam int IMM_LSB = 0;
  localparam int RSV_LSB = 0;
  localparam int RSV_W   = 6;

  // Execute-stage operation codes. 4'h9..4'hE are never produced.
  localparam logic [EXE_W-1:0] EXE_ADD     = 4'h0;
  localparam logic [EXE_W-1:0] EXE_SUB     = 4'h1;
  localparam logic [EXE_W-1:0] EXE_AND     = 4'h2;
  localparam logic [EXE_W-1:0] EXE_OR      = 4'h3;
  localparam logic [EXE_W-1:0] EXE_XOR     = 4'h4;
  localparam logic [EXE_W-1:0] EXE_SHL     = 4'h5;
  localparam logic [EXE_W-1:0] EXE_SHR     = 4'h6;
  localparam logic [EXE_W-1:0] EXE_MOV     = 4'h7;
  localparam logic [EXE_W-1:0] EXE_NOP     = 4'h8;
  localparam logic [EXE_W-1:0] EXE_ILLEGAL = 4'hF;

  // One complete decode, as handed to the execute stage.
  typedef struct packed {
    logic [EXE_W-1:0]     exe_op;
    logic [REG_IDX_W-1:0] dst_idx;
    logic [REG_IDX_W-1:0] in1_idx;
    logic [REG_IDX_W-1:0] in2_idx;
    logic [IMM_W-1:0]     imm_val;
    logic                 imm_sel;
  } decode_t;

  localparam decode_t DECODE_NOP = '{
    exe_op:  EXE_NOP,
    dst_idx: '0,
    in1_idx: '0,
    in2_idx: '0,
    imm_val: '0,
    imm_sel: 1'b0
  };

endpackage

// File: rtl/insn_decode_function_comb.sv
// Pure combinational field decode of one instruction word.
module insn_decode_function_comb
  import insn_decode_function_pkg::*;
(
  input  logic [15:0] instr_i,
  output logic [3:0]  exe_op_o,
  output logic [1:0]  dst_idx_o,
  output logic [1:0]  in1_idx_o,
  output logic [1:0]  in2_idx_o,
  output logic [7:0]  imm_val_o,
  output logic        imm_sel_o
);

  logic             is_imm;
  logic [RSV_W-1:0] rsv_bits;

  assign is_imm   = instr_i[I_BIT];
  assign rsv_bits = instr_i[RSV_LSB +: RSV_W];

  // Select register form, immediate form or illegal from the form bit and reserved field.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    exe_op_o  = EXE_ILLEGAL;
    dst_idx_o = '0;
    in1_idx_o = '0;
    in2_idx_o = '0;
    imm_val_o = '0;
    imm_sel_o = 1'b0;
    if (is_imm) begin
      exe_op_o  = {1'b0, instr_i[OP_LSB +: OP_W]};
      dst_idx_o = instr_i[DST_LSB +: REG_IDX_W];
      in1_idx_o = instr_i[IN1_LSB +: REG_IDX_W];
      imm_val_o = instr_i[IMM_LSB +: IMM_W];
      imm_sel_o = 1'b1;
    end else if (rsv_bits == '0) begin
      exe_op_o  = {1'b0, instr_i[OP_LSB +: OP_W]};
      dst_idx_o = instr_i[DST_LSB +: REG_IDX_W];
      in1_idx_o = instr_i[IN1_LSB +: REG_IDX_W];
      in2_idx_o = instr_i[IN2_LSB +: REG_IDX_W];
    end
  end

endmodule

// File: rtl/insn_decode_function.sv
// Instruction decoder: combinational field decode followed by one output
// register stage, so every decode appears one clock after it is sampled.
module insn_decode_function
  import insn_decode_function_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [15:0] iINSTRUCTION,
  output logic [3:0]  oDECODE_EXE_OPCODE,
  output logic [1:0]  oDECODE_IN1_IDX,
  output logic [1:0]  oDECODE_IN2_IDX,
  output logic [7:0]  oDECODE_IMM_VAL,
  output logic [1:0]  oDECODE_DEST_IDX,
  output logic        oDECODE_SRC1_IS_REG_OR_IMM
);

  decode_t dec_d;
  decode_t dec_q;

  insn_decode_function_comb u_comb (
    .instr_i   (iINSTRUCTION),
    .exe_op_o  (dec_d.exe_op),
    .dst_idx_o (dec_d.dst_idx),
    .in1_idx_o (dec_d.in1_idx),
    .in2_idx_o (dec_d.in2_idx),
    .imm_val_o (dec_d.imm_val),
    .imm_sel_o (dec_d.imm_sel)
  );

  // Load a fresh decode every edge; reset overrides it with a NOP.
  always_ff @(posedge iCLK) begin
    // NOTE: reset is sampled only on the clock edge, and state uses <= so all
    // fields update together from the same pre-edge values.
    if (!iRST) begin
      dec_q <= DECODE_NOP;
    end else begin
      dec_q <= dec_d;
    end
  end

  assign oDECODE_EXE_OPCODE         = dec_q.exe_op;
  assign oDECODE_DEST_IDX           = dec_q.dst_idx;
  assign oDECODE_IN1_IDX            = dec_q.in1_idx;
  assign oDECODE_IN2_IDX            = dec_q.in2_idx;
  assign oDECODE_IMM_VAL            = dec_q.imm_val;
  assign oDECODE_SRC1_IS_REG_OR_IMM = dec_q.imm_sel;

endmodule

// File: tb/tb_insn_decode_function.sv
// Directed bench for insn_decode_function: each step drives one instruction,
// queues the expected decode, and compares it one edge later.
module tb_insn_decode_function;

  typedef struct packed {
    logic [3:0] exe;
    logic [1:0] dst;
    logic [1:0] in1;
    logic [1:0] in2;
    logic [7:0] imm;
    logic       flag;
  } exp_t;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [15:0] iINSTRUCTION = '0;
  logic [3:0]  oDECODE_EXE_OPCODE;
  logic [1:0]  oDECODE_IN1_IDX;
  logic [1:0]  oDECODE_IN2_IDX;
  logic [7:0]  oDECODE_IMM_VAL;
  logic [1:0]  oDECODE_DEST_IDX;
  logic        oDECODE_SRC1_IS_REG_OR_IMM;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  insn_decode_function dut (
    .iCLK                       (iCLK),
    .iRST                       (iRST),
    .iINSTRUCTION               (iINSTRUCTION),
    .oDECODE_EXE_OPCODE         (oDECODE_EXE_OPCODE),
    .oDECODE_IN1_IDX            (oDECODE_IN1_IDX),
    .oDECODE_IN2_IDX            (oDECODE_IN2_IDX),
    .oDECODE_IMM_VAL            (oDECODE_IMM_VAL),
    .oDECODE_DEST_IDX           (oDECODE_DEST_IDX),
    .oDECODE_SRC1_IS_REG_OR_IMM (oDECODE_SRC1_IS_REG_OR_IMM)
  );

  always #5 iCLK = ~iCLK;

  function automatic exp_t mk(input logic [3:0] exe, input logic [1:0] dst,
                              input logic [1:0] in1, input logic [1:0] in2,
                              input logic [7:0] imm, input logic flag);
    exp_t e;
    e.exe  = exe;
    e.dst  = dst;
    e.in1  = in1;
    e.in2  = in2;
    e.imm  = imm;
    e.flag = flag;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one edge's inputs, queue the expected decode, then check it #1 after the edge.
  task automatic step(input string name, input logic rst, input logic [15:0] instr,
                      input exp_t expected);
    exp_t e;
    iRST         = rst;
    iINSTRUCTION = instr;
    sb_q.push_back(expected);
    @(posedge iCLK);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s scoreboard: observed empty queue expected one entry", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, ".exe"},  {4'h0, oDECODE_EXE_OPCODE},         {4'h0, e.exe});
      chk({name, ".dst"},  {6'h0, oDECODE_DEST_IDX},           {6'h0, e.dst});
      chk({name, ".in1"},  {6'h0, oDECODE_IN1_IDX},            {6'h0, e.in1});
      chk({name, ".in2"},  {6'h0, oDECODE_IN2_IDX},            {6'h0, e.in2});
      chk({name, ".imm"},  oDECODE_IMM_VAL,                    e.imm);
      chk({name, ".flag"}, {7'h0, oDECODE_SRC1_IS_REG_OR_IMM}, {7'h0, e.flag});
    end
  endtask

  initial begin
    // Reset with a live instruction present: reset must win on both edges.
    step("rst0", 1'b0, 16'h995A, mk(4'h8, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0));
    step("rst1", 1'b0, 16'h995A, mk(4'h8, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0));
    // First edge out of reset latches normally.
    step("add_reg", 1'b1, 16'h06C0, mk(4'h0, 2'd1, 2'd2, 2'd3, 8'h00, 1'b0));
    step("sub_imm", 1'b1, 16'h995A, mk(4'h1, 2'd2, 2'd1, 2'd0, 8'h5A, 1'b1));
    step("mov_immff", 1'b1, 16'hF0FF, mk(4'h7, 2'd0, 2'd0, 2'd0, 8'hFF, 1'b1));
    step("ill_b0", 1'b1, 16'h06C1, mk(4'hF, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0));
    // Register-form XOR: OP=4, DST=2, IN1=3, IN2=1.
    step("xor_reg", 1'b1, 16'h4B40, mk(4'h4, 2'd2, 2'd3, 2'd1, 8'h00, 1'b0));
    // Reserved bit 5 set in register form is illegal.
    step("ill_b5", 1'b1, 16'h7E20, mk(4'hF, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0));
    // Immediate form ignores what would be reserved bits; imm=0 boundary, SHR.
    step("shr_imm0", 1'b1, 16'hEF00, mk(4'h6, 2'd3, 2'd3, 2'd0, 8'h00, 1'b1));
    // Back-to-back then mid-stream reset: ADD, SUB, NOP on consecutive edges.
    step("b2b_add", 1'b1, 16'h06C0, mk(4'h0, 2'd1, 2'd2, 2'd3, 8'h00, 1'b0));
    step("b2b_sub", 1'b1, 16'h995A, mk(4'h1, 2'd2, 2'd1, 2'd0, 8'h5A, 1'b1));
    step("b2b_rst", 1'b0, 16'hF0FF, mk(4'h8, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0));
    // Recovery after the mid-stream reset.
    step("post_rst", 1'b1, 16'hF0FF, mk(4'h7, 2'd0, 2'd0, 2'd0, 8'hFF, 1'b1));
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
